// File: rtl/stateful_alu_pkg.sv
// stateful_alu_pkg: opcodes, FSM states and page-table field widths shared by stateful_alu.
package stateful_alu_pkg;
   localparam int OPC_W       = 8;
   localparam int PAGE_BASE_W = 8;
   localparam int PAGE_LEN_W  = 8;
   localparam logic [OPC_W-1:0] OP_ADD   = 8'h01;
   localparam logic [OPC_W-1:0] OP_ADDI  = 8'h09;
   localparam logic [OPC_W-1:0] OP_SUB   = 8'h02;
   localparam logic [OPC_W-1:0] OP_SUBI  = 8'h0A;
   localparam logic [OPC_W-1:0] OP_MOV   = 8'h0E;
   localparam logic [OPC_W-1:0] OP_EQ    = 8'h06;
   localparam logic [OPC_W-1:0] OP_GE    = 8'h18;
   localparam logic [OPC_W-1:0] OP_LT    = 8'h1C;
   localparam logic [OPC_W-1:0] OP_SEL   = 8'h10;
   localparam logic [OPC_W-1:0] OP_LOAD  = 8'h0B;
   localparam logic [OPC_W-1:0] OP_STORE = 8'h08;
   localparam logic [OPC_W-1:0] OP_INC   = 8'h07;
   localparam logic [OPC_W-1:0] OP_WRAP  = 8'h0C;
   localparam logic [OPC_W-1:0] OP_FADD  = 8'h0D;

   typedef enum logic [1:0] {IDLE, RD, EXEC, OUT} state_t;

   function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
      return opc inside {OP_LOAD, OP_STORE, OP_INC, OP_WRAP, OP_FADD};
   endfunction
endpackage

// File: rtl/stateful_alu_ram.sv
// alu_data_ram: simple dual-port RAM, registered read, write-first on address collision.
module alu_data_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 32,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/stateful_alu.sv
// stateful_alu: single-action ALU with a private data RAM for read-modify-write memory ops.
// Define STATEFUL_ALU_ISOLATION_EN to relocate and bound memory offsets through page_tbl_in.
module stateful_alu
   import stateful_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 32,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int ACTION_LEN = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ACTION_LEN-1:0] action_in,
   input  logic                  action_valid,
   input  logic [DATA_WIDTH-1:0] operand_1_in,
   input  logic [DATA_WIDTH-1:0] operand_2_in,
   input  logic [DATA_WIDTH-1:0] operand_3_in,
   input  logic [15:0]           page_tbl_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] container_out,
   output logic                  container_out_valid,
   input  logic                  ready_in,
   output logic                  overflow_out
);
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   state_t                state_q;
   logic [OPC_W-1:0]      opc_d, opc_q;
   logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q, container_q, wdata_q;
   logic [DATA_WIDTH-1:0] rdata, alu_res, mem_res, mem_new;
   logic [ADDR_WIDTH-1:0] offset, addr_d, addr_q;
   logic                  ovf_d, ovf_q, mem_op_q, we_q, valid_q, overflow_q;
   logic                  unused_bits;

   assign opc_d  = action_in[ACTION_LEN-1 -: OPC_W];
   assign offset = operand_2_in[ADDR_WIDTH-1:0];

`ifdef STATEFUL_ALU_ISOLATION_EN
   assign addr_d      = offset + ADDR_WIDTH'(page_tbl_in[PAGE_BASE_W-1:0]);
   assign ovf_d       = 32'(offset) > 32'(page_tbl_in[15 -: PAGE_LEN_W]);
   assign unused_bits = ^action_in[ACTION_LEN-OPC_W-1:0];
`else
   assign addr_d      = offset;
   assign ovf_d       = 1'b0;
   assign unused_bits = ^{action_in[ACTION_LEN-OPC_W-1:0], page_tbl_in};
`endif

   always_comb begin
      case (opc_q)
         OP_ADD, OP_ADDI: alu_res = op1_q + op2_q;
         OP_SUB, OP_SUBI: alu_res = op1_q - op2_q;
         OP_MOV:          alu_res = op2_q;
         OP_EQ:           alu_res = DATA_WIDTH'(op1_q == op2_q);
         OP_GE:           alu_res = DATA_WIDTH'(op1_q >= op2_q);
         OP_LT:           alu_res = DATA_WIDTH'(op1_q < op2_q);
         OP_SEL:          alu_res = (op1_q != '0) ? op2_q : op3_q;
         default:         alu_res = op3_q;
      endcase
   end

   // New RAM word for the read-modify-write ops; loads never write it back.
   assign mem_new = (opc_q == OP_STORE) ? op1_q :
                    (opc_q == OP_WRAP)  ? ((rdata == op1_q) ? '0 : rdata + ONE) :
                    (opc_q == OP_FADD)  ? rdata + op1_q : rdata + ONE;
   assign mem_res = (ovf_q || opc_q == OP_STORE) ? op3_q : rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         opc_q       <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         op3_q       <= '0;
         addr_q      <= '0;
         mem_op_q    <= 1'b0;
         ovf_q       <= 1'b0;
         container_q <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (action_valid) begin
               opc_q    <= opc_d;
               op1_q    <= operand_1_in;
               op2_q    <= operand_2_in;
               op3_q    <= operand_3_in;
               addr_q   <= addr_d;
               mem_op_q <= is_mem_op(opc_d);
               ovf_q    <= is_mem_op(opc_d) && ovf_d;
               state_q  <= is_mem_op(opc_d) ? RD : EXEC;
            end
            RD: state_q <= EXEC;
            EXEC: begin
               container_q <= mem_op_q ? mem_res : alu_res;
               overflow_q  <= ovf_q;
               wdata_q     <= mem_new;
               we_q        <= mem_op_q && !ovf_q && opc_q != OP_LOAD;
               valid_q     <= 1'b1;
               state_q     <= OUT;
            end
            OUT: if (ready_in) begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   alu_data_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .we_i   (state_q == OUT && ready_in && we_q),
      .waddr_i(addr_q),
      .wdata_i(wdata_q),
      .re_i   (state_q == RD),
      .raddr_i(addr_q),
      .rdata_o(rdata)
   );

   assign ready_out           = state_q == IDLE;
   assign container_out       = container_q;
   assign container_out_valid = valid_q;
   assign overflow_out        = overflow_q;
endmodule

// File: tb/tb_stateful_alu.sv
// tb_stateful_alu: directed table-driven checks of stateful_alu plus multi-cycle corner sequences.
module tb_stateful_alu;
   localparam logic [15:0] PG_OK = 16'hFF00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] action_in = '0;
   logic        action_valid = 1'b0;
   logic [31:0] operand_1_in = '0, operand_2_in = '0, operand_3_in = '0;
   logic [15:0] page_tbl_in = '0;
   logic        ready_out, container_out_valid, overflow_out;
   logic [31:0] container_out;
   logic        ready_in = 1'b0;
   int          n_chk = 0, n_fail = 0;

   typedef struct {
      logic [7:0]  opc;
      logic [31:0] a, b, c, exp;
   } vec_t;
   vec_t vecs[15];

   stateful_alu dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .action_in          (action_in),
      .action_valid       (action_valid),
      .operand_1_in       (operand_1_in),
      .operand_2_in       (operand_2_in),
      .operand_3_in       (operand_3_in),
      .page_tbl_in        (page_tbl_in),
      .ready_out          (ready_out),
      .container_out      (container_out),
      .container_out_valid(container_out_valid),
      .ready_in           (ready_in),
      .overflow_out       (overflow_out)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Entered and left at a falling edge; hold = cycles ready_in stays low once the result is valid.
   task automatic run(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [15:0] pg, input int hold,
                      input logic [31:0] exp_res, input logic exp_ovf, input string nm);
      int n;
      int exp_lat;
      exp_lat = (opc inside {8'h0B, 8'h08, 8'h07, 8'h0C, 8'h0D}) ? 2 : 1;
      n = 0;
      while (!ready_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " ready"}, 32'(ready_out), 32'd1);
      action_in    = {opc, 56'h00C0_FFEE_0000_00};
      action_valid = 1'b1;
      operand_1_in = a;
      operand_2_in = b;
      operand_3_in = c;
      page_tbl_in  = pg;
      ready_in     = (hold == 0);
      @(negedge clk);
      action_valid = 1'b0;
      operand_1_in = $urandom;
      operand_2_in = $urandom;
      operand_3_in = $urandom;
      page_tbl_in  = 16'($urandom);
      n = 0;
      while (!container_out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 32'(n), 32'(exp_lat));
      chk({nm, " result"}, container_out, exp_res);
      chk({nm, " overflow"}, 32'(overflow_out), 32'(exp_ovf));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, " held result"}, container_out, exp_res);
         chk({nm, " held flags"}, {29'd0, container_out_valid, ready_out, overflow_out}, {29'd0, 2'b10, exp_ovf});
      end
      ready_in = 1'b1;
      @(negedge clk);
      ready_in = 1'b0;
      chk({nm, " release"}, {30'd0, container_out_valid, ready_out}, 32'b01);
   endtask

   initial begin
      vecs[0]  = '{8'h01, 32'hFFFF_FFFF, 32'd2,         32'h0,  32'd1};
      vecs[1]  = '{8'h09, 32'd5,         32'd7,         32'h0,  32'd12};
      vecs[2]  = '{8'h02, 32'd3,         32'd5,         32'h0,  32'hFFFF_FFFE};
      vecs[3]  = '{8'h0A, 32'h10,        32'd1,         32'h0,  32'hF};
      vecs[4]  = '{8'h0E, 32'd1,         32'hAB,        32'h0,  32'hAB};
      vecs[5]  = '{8'h06, 32'd7,         32'd7,         32'h0,  32'd1};
      vecs[6]  = '{8'h06, 32'd7,         32'd8,         32'h0,  32'd0};
      vecs[7]  = '{8'h18, 32'd5,         32'd5,         32'h0,  32'd1};
      vecs[8]  = '{8'h18, 32'd4,         32'd5,         32'h0,  32'd0};
      vecs[9]  = '{8'h18, 32'hFFFF_FFFF, 32'd1,         32'h0,  32'd1};
      vecs[10] = '{8'h1C, 32'hFFFF_FFFF, 32'd1,         32'h0,  32'd0};
      vecs[11] = '{8'h1C, 32'd1,         32'd2,         32'h0,  32'd1};
      vecs[12] = '{8'h10, 32'd1,         32'h22,        32'h33, 32'h22};
      vecs[13] = '{8'h10, 32'd0,         32'h22,        32'h33, 32'h33};
      vecs[14] = '{8'h3F, 32'd4,         32'd5,         32'h99, 32'h99};

      @(negedge clk);
      chk("reset ready_out", 32'(ready_out), 32'd1);
      chk("reset valid", 32'(container_out_valid), 32'd0);
      chk("reset container", container_out, 32'd0);
      chk("reset overflow", 32'(overflow_out), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++)
         run(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].c, PG_OK, 0, vecs[i].exp, 1'b0,
             $sformatf("alu%0d", i));

      run(8'h08, 32'h55, 32'd3, 32'hAA, PG_OK, 0, 32'hAA, 1'b0, "store w3");
      run(8'h0B, 32'h0,  32'd3, 32'h0,  PG_OK, 0, 32'h55, 1'b0, "load w3");

      run(8'h08, 32'h0, 32'd0, 32'h0, PG_OK, 0, 32'h0, 1'b0, "clear w0");
      run(8'h0C, 32'd2, 32'd0, 32'h0, PG_OK, 0, 32'd0, 1'b0, "wrap1");
      run(8'h0C, 32'd2, 32'd0, 32'h0, PG_OK, 0, 32'd1, 1'b0, "wrap2");
      run(8'h0C, 32'd2, 32'd0, 32'h0, PG_OK, 0, 32'd2, 1'b0, "wrap3");
      run(8'h0C, 32'd2, 32'd0, 32'h0, PG_OK, 0, 32'd0, 1'b0, "wrap4");

      run(8'h08, 32'd10, 32'd6, 32'h7,  PG_OK, 0, 32'h7,  1'b0, "store w6");
      run(8'h07, 32'h0,  32'd6, 32'h5,  PG_OK, 5, 32'd10, 1'b0, "inc w6 held");
      run(8'h0B, 32'h0,  32'd6, 32'h0,  PG_OK, 0, 32'd11, 1'b0, "load w6");
      run(8'h08, 32'h1234, 32'd5, 32'h3C, PG_OK, 5, 32'h3C, 1'b0, "store w5 held");
      run(8'h0B, 32'h0,  32'd5, 32'h0,  PG_OK, 0, 32'h1234, 1'b0, "load w5");

      run(8'h08, 32'd100, 32'd7, 32'h9, PG_OK, 0, 32'h9, 1'b0, "store w7");
      action_in    = {8'h0D, 56'h0};
      action_valid = 1'b1;
      operand_1_in = 32'd5;
      operand_2_in = 32'd7;
      operand_3_in = 32'h0;
      page_tbl_in  = PG_OK;
      ready_in     = 1'b1;
      @(negedge clk);
      action_valid = 1'b0;
      chk("fadd busy", 32'(ready_out), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort ready_out", 32'(ready_out), 32'd1);
      chk("abort valid", 32'(container_out_valid), 32'd0);
      chk("abort container", container_out, 32'd0);
      chk("abort overflow", 32'(overflow_out), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      ready_in = 1'b0;
      run(8'h0B, 32'h0, 32'd7, 32'h0, PG_OK, 0, 32'd100, 1'b0, "load w7 after abort");
      run(8'h0D, 32'd5, 32'd7, 32'h0, PG_OK, 0, 32'd100, 1'b0, "fadd w7");
      run(8'h0B, 32'h0, 32'd7, 32'h0, PG_OK, 0, 32'd105, 1'b0, "load w7 after fadd");

      run(8'h08, 32'h13, 32'd13, 32'h0, PG_OK, 0, 32'h0, 1'b0, "store w13");
`ifdef STATEFUL_ALU_ISOLATION_EN
      run(8'h0B, 32'h0,  32'd5, 32'h77, 16'h0408, 0, 32'h77, 1'b1, "iso load ovf");
      run(8'h08, 32'hEE, 32'd5, 32'h66, 16'h0408, 0, 32'h66, 1'b1, "iso store ovf");
      run(8'h0B, 32'h0,  32'd13, 32'h11, PG_OK,   0, 32'h13, 1'b0, "w13 unchanged");
      run(8'h08, 32'h42, 32'd2, 32'h1,  16'h0408, 0, 32'h1,  1'b0, "iso store in page");
      run(8'h0B, 32'h0,  32'd10, 32'h0, PG_OK,    0, 32'h42, 1'b0, "load w10");
`else
      run(8'h0B, 32'h0, 32'd13, 32'h77, 16'h0408, 0, 32'h13, 1'b0, "page ignored");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/stateful_alu.md
STATEFUL_ALU -- requirements
Module: stateful_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of operands, result and RAM words.
REQ-002 Parameter MEM_DEPTH, default 32, number of RAM words; power of two, 16 to 1024.
REQ-003 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), width of the RAM address; derived, never overridden.
REQ-004 Parameter ACTION_LEN, default 64, action word width; the opcode SHALL be action_in[ACTION_LEN-1 -: 8].
REQ-005 Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- action_in  in  ACTION_LEN  action word.
- action_valid  in  1  action present.
- operand_1_in, operand_2_in, operand_3_in  in  DATA_WIDTH each  operands; operand_2_in[ADDR_WIDTH-1:0] is the memory offset.
- page_tbl_in  in  16  {addr_len[15:8], base_addr[7:0]} tenant page.
- ready_out  out  1  block can accept an action.
- container_out  out  DATA_WIDTH  result.
- container_out_valid  out  1  result valid; held until taken.
- ready_in  in  1  downstream accepts the result.
- overflow_out  out  1  result belongs to an out-of-page memory access.

Function
REQ-006 An action SHALL be accepted only in a cycle where action_valid and ready_out are both 1; operands and page_tbl_in are sampled in that cycle only.
REQ-007 State machine: IDLE -> EXEC (ALU ops) or IDLE -> RD (memory ops) -> EXEC; EXEC -> OUT; OUT -> IDLE when ready_in is 1; ready_out is 1 only in IDLE.
REQ-008 Latency: ALU result valid 1 cycle after acceptance; memory result valid 2 cycles after acceptance (1-cycle RAM read).
REQ-009 container_out and overflow_out SHALL stay stable while container_out_valid=1 and ready_in=0.
REQ-010 ALU ops, modulo 2^DATA_WIDTH: 0x01/0x09 op1+op2; 0x02/0x0A op1-op2; 0x0E op2; 0x06 (op1==op2); 0x18 (op1>=op2, unsigned); 0x1C (op1<op2, unsigned); 0x10 op1!=0 ? op2 : op3; any other opcode op3.
REQ-011 Memory ops output the old word M (for store, op3): 0x0B load; 0x08 store op1; 0x07 store M+1; 0x0C wrap-increment, store 0 if M==op1 else M+1; 0x0D fetch-add, store M+op1.
REQ-012 RAM write SHALL occur exactly once, in the OUT cycle where ready_in=1; no write on overflow or for 0x0B.
REQ-013 An access accepted in the cycle after a write to the same address SHALL read the new value; the RAM is write-first or has a one-entry bypass.
REQ-014 On overflow (REQ-019): container_out=op3, overflow_out=1, no RAM write.
REQ-015 ready_in=1 already in the first OUT cycle SHALL give a 1-cycle OUT and a 1-cycle container_out_valid pulse.

Reset
REQ-016 When rst_n=0, state SHALL go to IDLE immediately; ready_out=1, container_out=0, container_out_valid=0, overflow_out=0.
REQ-017 Reset in RD/EXEC/OUT SHALL abort the action with no RAM write; RAM contents are not cleared.
REQ-018 The first action SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-019 With macro STATEFUL_ALU_ISOLATION_EN defined: physical address = (base_addr + offset) mod MEM_DEPTH; overflow when offset > addr_len.
REQ-020 Without STATEFUL_ALU_ISOLATION_EN: physical address = offset, page_tbl_in ignored, overflow_out constant 0.

Structure
REQ-021 Package stateful_alu_pkg SHALL hold the opcode constants, the state enum (IDLE, RD, EXEC, OUT) and the page-entry field widths.
REQ-022 Sub-module alu_data_ram: simple dual-port, MEM_DEPTH x DATA_WIDTH, 1-cycle registered read, write-first on address collision.

Verification
REQ-023 add 0x01, op1=0xFFFFFFFF, op2=2 -> container_out=1, valid 1 cycle after acceptance, overflow_out=0.
REQ-024 store 0x08 op1=0x55, offset 3, then load 0x0B offset 3 issued the cycle ready_out returns -> load result 0x55.
REQ-025 wrap-increment 0x0C, op1=2, offset 0 (word 0), issued 4 times -> outputs 0,1,2,0.
REQ-026 ISOLATION_EN, page {addr_len=4, base_addr=8}, load offset 5, op3=0x77 -> container_out=0x77, overflow_out=1, word 13 unchanged.
REQ-027 ready_in held 0 for 5 cycles after valid -> container_out stable, ready_out=0, store written once on the release cycle.
REQ-028 rst_n pulsed low during RD of a fetch-add -> outputs at reset values, RAM word unchanged, next action accepted normally.
